// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: serialises data and instruction accesses onto one
// RAM port (data first), pulses ihit/dhit on completion, flags stalled RAM via merr.
module mem_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        merr,
  output logic [2:0]  dbg_state
);

  // Handshake: iREN/dREN/dWEN are levels sampled only in IDLE; once sampled the
  // access runs to completion (hit) or timeout regardless of the request level.
  // ramready is a one-cycle completion honoured only while a strobe is up.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          ren_n, wen_n, ihit_n, dhit_n, merr_n;
  logic [31:0]   addr_n, store_n, iload_n, dload_n;

  assign dbg_state = state;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      cnt      <= '0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      ihit     <= 1'b0;
      dhit     <= 1'b0;
      iload    <= '0;
      dload    <= '0;
      merr     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ramREN   <= ren_n;
      ramWEN   <= wen_n;
      ramaddr  <= addr_n;
      ramstore <= store_n;
      ihit     <= ihit_n;
      dhit     <= dhit_n;
      iload    <= iload_n;
      dload    <= dload_n;
      merr     <= merr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ren_n   = ramREN;
    wen_n   = ramWEN;
    addr_n  = ramaddr;
    store_n = ramstore;
    ihit_n  = 1'b0;
    dhit_n  = 1'b0;
    iload_n = iload;
    dload_n = dload;
    merr_n  = merr;

    unique case (state)
      IDLE: begin
        if (dWEN || dREN) begin
          state_n = DACC;
          wen_n   = dWEN;
          ren_n   = !dWEN;
          addr_n  = daddr;
          store_n = dstore;
          cnt_n   = '0;
        end else if (iREN) begin
          state_n = IACC;
          ren_n   = 1'b1;
          wen_n   = 1'b0;
          addr_n  = iaddr;
          cnt_n   = '0;
        end
      end

      DACC: begin
        if (ramready) begin
          // ramWEN still holds the latched op, so writes leave dload alone
          if (!ramWEN) dload_n = ramload;
          state_n = DRESP;
          dhit_n  = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          merr_n  = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      IACC: begin
        if (ramready) begin
          iload_n = ramload;
          state_n = IRESP;
          ihit_n  = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
          merr_n  = 1'b1;
          ren_n   = 1'b0;
          wen_n   = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      DRESP: state_n = IDLE;

      IRESP: state_n = IDLE;

      default: begin
        state_n = IDLE;
        ren_n   = 1'b0;
        wen_n   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=4): reset, fetch, priority, write,
// timeout/retry and asynchronous reset during an access.
module tb_mem_arbiter;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DACC = 3'd1;
  localparam logic [2:0] S_IACC = 3'd2;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0, ramready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic        ihit, dhit, ramREN, ramWEN, merr;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready),
    .merr(merr), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  // Never both hits, never both strobes, in any cycle out of reset.
  always @(negedge CLK) begin
    if (nRST) begin
      checks++;
      if (ihit && dhit) begin
        errors++;
        $display("FAIL both_hits ihit=%0b dhit=%0b required not both", ihit, dhit);
      end
      checks++;
      if (ramREN && ramWEN) begin
        errors++;
        $display("FAIL both_strobes ren=%0b wen=%0b required not both", ramREN, ramWEN);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #3;
    checks++;
    if ({ihit, dhit, ramREN, ramWEN, merr} !== 5'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_ctrl got %b st=%0d required 00000 st=0",
               {ihit, dhit, ramREN, ramWEN, merr}, dbg_state);
    end
    checks++;
    if ({iload, dload, ramaddr, ramstore} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 0", {iload, dload, ramaddr, ramstore});
    end
    tick();
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dbg_state !== S_IDLE) begin
        errors++;
        $display("FAIL idle_hold cycle %0d ren=%0b wen=%0b st=%0d required 0 0 0",
                 i, ramREN, ramWEN, dbg_state);
      end
    end
  endtask

  task automatic test_fetch();
    iREN = 1'b1;
    iaddr = 32'h40;
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
        errors++;
        $display("FAIL fetch_strobe cyc %0d ren=%0b wen=%0b addr=%h ihit=%0b required 1 0 40 0",
                 i, ramREN, ramWEN, ramaddr, ihit);
      end
      if (i == 3) begin
        ramready = 1'b1;
        ramload = 32'h8C220004;
      end
    end
    tick();
    checks++;
    if (ihit !== 1'b1 || iload !== 32'h8C220004 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL fetch_hit ihit=%0b iload=%h ren=%0b required 1 8c220004 0",
               ihit, iload, ramREN);
    end
    ramready = 1'b0;
    ramload = 32'hFFFFFFFF;
    iREN = 1'b0;
    tick();
    checks++;
    if (ihit !== 1'b0 || dbg_state !== S_IDLE || iload !== 32'h8C220004) begin
      errors++;
      $display("FAIL fetch_after ihit=%0b st=%0d iload=%h required 0 0 8c220004",
               ihit, dbg_state, iload);
    end
  endtask

  task automatic test_priority();
    iREN = 1'b1;
    iaddr = 32'h40;
    dREN = 1'b1;
    daddr = 32'h100;
    tick();
    checks++;
    if (dbg_state !== S_DACC || ramREN !== 1'b1 || ramaddr !== 32'h100) begin
      errors++;
      $display("FAIL prio_data_first st=%0d ren=%0b addr=%h required 1 1 100",
               dbg_state, ramREN, ramaddr);
    end
    ramready = 1'b1;
    ramload = 32'hDEADBEEF;
    tick();
    checks++;
    if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prio_dhit dhit=%0b ihit=%0b dload=%h required 1 0 deadbeef",
               dhit, ihit, dload);
    end
    ramready = 1'b0;
    dREN = 1'b0;
    tick();
    checks++;
    if (dbg_state !== S_IDLE || dhit !== 1'b0 || ramREN !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle st=%0d dhit=%0b ren=%0b required 0 0 0", dbg_state, dhit, ramREN);
    end
    tick();
    checks++;
    if (dbg_state !== S_IACC || ramREN !== 1'b1 || ramaddr !== 32'h40) begin
      errors++;
      $display("FAIL prio_fetch_next st=%0d ren=%0b addr=%h required 2 1 40",
               dbg_state, ramREN, ramaddr);
    end
    ramready = 1'b1;
    ramload = 32'h11112222;
    tick();
    checks++;
    if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h11112222 || dload !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL prio_ihit ihit=%0b dhit=%0b iload=%h dload=%h required 1 0 11112222 deadbeef",
               ihit, dhit, iload, dload);
    end
    ramready = 1'b0;
    iREN = 1'b0;
    tick();
  endtask

  task automatic test_write();
    dWEN = 1'b1;
    dREN = 1'b1;
    daddr = 32'h200;
    dstore = 32'h12345678;
    tick();
    checks++;
    if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h200 || ramstore !== 32'h12345678) begin
      errors++;
      $display("FAIL write_strobe wen=%0b ren=%0b addr=%h store=%h required 1 0 200 12345678",
               ramWEN, ramREN, ramaddr, ramstore);
    end
    ramready = 1'b1;
    ramload = 32'hCAFEF00D;
    tick();
    checks++;
    if (dhit !== 1'b1 || dload !== 32'hDEADBEEF || ramWEN !== 1'b0) begin
      errors++;
      $display("FAIL write_hit dhit=%0b dload=%h wen=%0b required 1 deadbeef 0",
               dhit, dload, ramWEN);
    end
    ramready = 1'b0;
    dWEN = 1'b0;
    dREN = 1'b0;
    tick();
    checks++;
    if (dbg_state !== S_IDLE || dhit !== 1'b0) begin
      errors++;
      $display("FAIL write_idle st=%0d dhit=%0b required 0 0", dbg_state, dhit);
    end
  endtask

  task automatic test_timeout();
    iREN = 1'b1;
    iaddr = 32'h80;
    ramready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (ramREN !== 1'b1 || merr !== 1'b0 || ihit !== 1'b0) begin
        errors++;
        $display("FAIL timeout_strobe cyc %0d ren=%0b merr=%0b ihit=%0b required 1 0 0",
                 i, ramREN, merr, ihit);
      end
    end
    tick();
    checks++;
    if (merr !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL timeout_abort merr=%0b ren=%0b ihit=%0b st=%0d required 1 0 0 0",
               merr, ramREN, ihit, dbg_state);
    end
    tick();
    checks++;
    if (dbg_state !== S_IACC || ramREN !== 1'b1 || ramaddr !== 32'h80) begin
      errors++;
      $display("FAIL timeout_retry st=%0d ren=%0b addr=%h required 2 1 80",
               dbg_state, ramREN, ramaddr);
    end
    ramready = 1'b1;
    ramload = 32'h00000055;
    tick();
    checks++;
    if (ihit !== 1'b1 || iload !== 32'h55 || merr !== 1'b1) begin
      errors++;
      $display("FAIL timeout_retry_hit ihit=%0b iload=%h merr=%0b required 1 55 1",
               ihit, iload, merr);
    end
    ramready = 1'b0;
    iREN = 1'b0;
    tick();
    tick();
    checks++;
    if (merr !== 1'b1) begin
      errors++;
      $display("FAIL merr_sticky merr=%0b required 1", merr);
    end
  endtask

  task automatic test_reset_mid_access();
    dREN = 1'b1;
    daddr = 32'h300;
    tick();
    checks++;
    if (ramREN !== 1'b1 || dbg_state !== S_DACC) begin
      errors++;
      $display("FAIL midrst_start ren=%0b st=%0d required 1 1", ramREN, dbg_state);
    end
    #1;
    nRST = 1'b0;
    #1;
    checks++;
    if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dhit !== 1'b0 || merr !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL midrst_async ren=%0b wen=%0b dhit=%0b merr=%0b st=%0d required 0 0 0 0 0",
               ramREN, ramWEN, dhit, merr, dbg_state);
    end
    tick();
    nRST = 1'b1;
    tick();
    checks++;
    if (ramREN !== 1'b1 || ramaddr !== 32'h300 || dbg_state !== S_DACC) begin
      errors++;
      $display("FAIL midrst_restart ren=%0b addr=%h st=%0d required 1 300 1",
               ramREN, ramaddr, dbg_state);
    end
    ramready = 1'b1;
    ramload = 32'hA5A5A5A5;
    tick();
    checks++;
    if (dhit !== 1'b1 || dload !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL midrst_hit dhit=%0b dload=%h required 1 a5a5a5a5", dhit, dload);
    end
    ramready = 1'b0;
    dREN = 1'b0;
    tick();
  endtask

  task automatic test_stray_ready();
    ramready = 1'b1;
    ramload = 32'h77777777;
    tick();
    tick();
    checks++;
    if (ihit !== 1'b0 || dhit !== 1'b0 || dload !== 32'hA5A5A5A5 || dbg_state !== S_IDLE) begin
      errors++;
      $display("FAIL stray_ready ihit=%0b dhit=%0b dload=%h st=%0d required 0 0 a5a5a5a5 0",
               ihit, dhit, dload, dbg_state);
    end
    ramready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_timeout();
    test_reset_mid_access();
    test_stray_ready();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
